// File: rtl/aes_kat_sequencer.sv
// Known-answer-test sequencer for one AES encrypt/decrypt core pair.
// Walks a vector table, checks both directions, tallies failures.
module aes_kat_sequencer #(
  parameter int KEY_BITS   = 128,
  parameter int NUM_VEC    = 4,
  parameter int IDX_W      = 2,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                loop_mode,
  input  logic                abort,
  output logic [IDX_W-1:0]    vec_idx,
  input  logic [127:0]        vec_pt,
  input  logic [KEY_BITS-1:0] vec_key,
  input  logic [127:0]        vec_ct,
  output logic [127:0]        core_pt,
  output logic [KEY_BITS-1:0] core_key,
  input  logic [127:0]        core_enc,
  input  logic [127:0]        core_dec,
  output logic                busy,
  output logic                done,
  output logic                all_pass,
  output logic [CNT_W-1:0]    enc_fail_cnt,
  output logic [CNT_W-1:0]    dec_fail_cnt,
  output logic [IDX_W-1:0]    first_fail_idx,
  output logic                first_fail_vld
);

  localparam int SC_W =
    (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SC_W-1:0] SC_INIT =
    SC_W'(SETTLE_CYC - 1);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  state_t           state;
  logic [127:0]     exp_ct;
  logic [SC_W-1:0]  settle_cnt;

  logic             enc_err;
  logic             dec_err;
  logic [CNT_W-1:0] enc_nxt;
  logic [CNT_W-1:0] dec_nxt;

  assign enc_err = (core_enc != exp_ct);
  assign dec_err = (core_dec != core_pt);

  // Saturating next-count values, also used for the run verdict
  always_comb begin
    enc_nxt = enc_fail_cnt;
    dec_nxt = dec_fail_cnt;
    if (enc_err && enc_fail_cnt != CNT_MAX)
      enc_nxt = enc_fail_cnt + CNT_W'(1);
    if (dec_err && dec_fail_cnt != CNT_MAX)
      dec_nxt = dec_fail_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      vec_idx        <= '0;
      core_pt        <= '0;
      core_key       <= '0;
      exp_ct         <= '0;
      settle_cnt     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      all_pass       <= 1'b0;
      enc_fail_cnt   <= '0;
      dec_fail_cnt   <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
    end else if (abort) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      all_pass <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state          <= LOAD;
            busy           <= 1'b1;
            vec_idx        <= '0;
            enc_fail_cnt   <= '0;
            dec_fail_cnt   <= '0;
            first_fail_vld <= 1'b0;
            all_pass       <= 1'b0;
          end
        end
        LOAD: begin
          core_pt    <= vec_pt;
          core_key   <= vec_key;
          exp_ct     <= vec_ct;
          settle_cnt <= SC_INIT;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == '0)
            state <= CHECK;
          else
            settle_cnt <= settle_cnt - SC_W'(1);
        end
        CHECK: begin
          enc_fail_cnt <= enc_nxt;
          dec_fail_cnt <= dec_nxt;
          if ((enc_err || dec_err) && !first_fail_vld) begin
            first_fail_idx <= vec_idx;
            first_fail_vld <= 1'b1;
          end
          if (vec_idx == LAST) begin
            state    <= DONE;
            done     <= 1'b1;
            all_pass <= (enc_nxt == '0) && (dec_nxt == '0);
          end else begin
            vec_idx <= vec_idx + IDX_W'(1);
            state   <= LOAD;
          end
        end
        DONE: begin
          done <= 1'b0;
          if (loop_mode) begin
            state          <= LOAD;
            vec_idx        <= '0;
            enc_fail_cnt   <= '0;
            dec_fail_cnt   <= '0;
            first_fail_vld <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_kat_sequencer.sv
// Directed bench: three sequencer instances with stub AES cores
// backed by known-answer tables.
module tb_aes_kat_sequencer;

  logic clk;
  logic reset;
  int   n_run;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] PT1 =
    128'hf34481ec3cc627bacd5dc3fb08f273e6;
  localparam logic [127:0] CT1 =
    128'h0336763e966d92595a567cc9ce537f5e;
  localparam logic [127:0] PT2 =
    128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY2 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT2 =
    128'h8ea2b7ca516745bfeafc49904b496089;

  // Instance A: 128-bit, 4 vectors
  logic         start_a, loop_a, abort_a;
  logic [1:0]   idx_a;
  logic [127:0] vpt_a, vct_a, cpt_a, enc_a, dec_a;
  logic [127:0] ckey_a, vkey_a;
  logic         busy_a, done_a, pass_a, ffv_a;
  logic [7:0]   ecnt_a, dcnt_a;
  logic [1:0]   ffi_a;
  logic [127:0] pt_a [4];
  logic [127:0] key_a [4];
  logic [127:0] ct_a [4];
  logic         ctflip_a, decflip_a;

  assign vpt_a  = pt_a[idx_a];
  assign vkey_a = key_a[idx_a];
  assign vct_a  = ct_a[idx_a] ^
    {127'b0, ctflip_a && idx_a == 2'd2};

  always_comb begin
    enc_a = ~cpt_a;
    for (int i = 0; i < 4; i++)
      if (cpt_a == pt_a[i] && ckey_a == key_a[i])
        enc_a = ct_a[i];
  end
  always_comb begin
    dec_a = '0;
    for (int i = 0; i < 4; i++)
      if (enc_a == ct_a[i])
        dec_a = pt_a[i];
    dec_a = dec_a ^ {127'b0, decflip_a};
  end

  aes_kat_sequencer #(
    .KEY_BITS(128), .NUM_VEC(4), .IDX_W(2),
    .SETTLE_CYC(2), .CNT_W(8)
  ) u_a (
    .clk(clk), .reset(reset), .start(start_a),
    .loop_mode(loop_a), .abort(abort_a),
    .vec_idx(idx_a), .vec_pt(vpt_a),
    .vec_key(vkey_a), .vec_ct(vct_a),
    .core_pt(cpt_a), .core_key(ckey_a),
    .core_enc(enc_a), .core_dec(dec_a),
    .busy(busy_a), .done(done_a), .all_pass(pass_a),
    .enc_fail_cnt(ecnt_a), .dec_fail_cnt(dcnt_a),
    .first_fail_idx(ffi_a), .first_fail_vld(ffv_a)
  );

  // Instance B: 128-bit, single vector
  logic         start_b, loop_b, abort_b;
  logic [0:0]   idx_b;
  logic [127:0] cpt_b, ckey_b, enc_b, dec_b;
  logic         busy_b, done_b, pass_b, ffv_b;
  logic [7:0]   ecnt_b, dcnt_b;
  logic [0:0]   ffi_b;

  assign enc_b = (cpt_b == PT1 && ckey_b == '0) ? CT1 : '0;
  assign dec_b = (enc_b == CT1) ? PT1 : '0;

  aes_kat_sequencer #(
    .KEY_BITS(128), .NUM_VEC(1), .IDX_W(1),
    .SETTLE_CYC(2), .CNT_W(8)
  ) u_b (
    .clk(clk), .reset(reset), .start(start_b),
    .loop_mode(loop_b), .abort(abort_b),
    .vec_idx(idx_b), .vec_pt(PT1),
    .vec_key(128'h0), .vec_ct(CT1),
    .core_pt(cpt_b), .core_key(ckey_b),
    .core_enc(enc_b), .core_dec(dec_b),
    .busy(busy_b), .done(done_b), .all_pass(pass_b),
    .enc_fail_cnt(ecnt_b), .dec_fail_cnt(dcnt_b),
    .first_fail_idx(ffi_b), .first_fail_vld(ffv_b)
  );

  // Instance C: 256-bit, 5 vectors, 2-bit counters
  logic         start_c, loop_c, abort_c;
  logic [2:0]   idx_c;
  logic [127:0] vpt_c, vct_c, cpt_c, enc_c, dec_c;
  logic [255:0] vkey_c, ckey_c;
  logic         busy_c, done_c, pass_c, ffv_c;
  logic [1:0]   ecnt_c, dcnt_c;
  logic [2:0]   ffi_c;
  logic [127:0] pt_c [5];
  logic [255:0] key_c [5];
  logic [127:0] ct_c [5];
  logic [4:0]   fmask_c;

  assign vpt_c  = pt_c[idx_c];
  assign vkey_c = key_c[idx_c];
  assign vct_c  = ct_c[idx_c] ^ {127'b0, fmask_c[idx_c]};

  always_comb begin
    enc_c = '0;
    for (int i = 0; i < 5; i++)
      if (cpt_c == pt_c[i] && ckey_c == key_c[i])
        enc_c = ct_c[i];
  end
  always_comb begin
    dec_c = '0;
    for (int i = 0; i < 5; i++)
      if (enc_c == ct_c[i])
        dec_c = pt_c[i];
  end

  aes_kat_sequencer #(
    .KEY_BITS(256), .NUM_VEC(5), .IDX_W(3),
    .SETTLE_CYC(2), .CNT_W(2)
  ) u_c (
    .clk(clk), .reset(reset), .start(start_c),
    .loop_mode(loop_c), .abort(abort_c),
    .vec_idx(idx_c), .vec_pt(vpt_c),
    .vec_key(vkey_c), .vec_ct(vct_c),
    .core_pt(cpt_c), .core_key(ckey_c),
    .core_enc(enc_c), .core_dec(dec_c),
    .busy(busy_c), .done(done_c), .all_pass(pass_c),
    .enc_fail_cnt(ecnt_c), .dec_fail_cnt(dcnt_c),
    .first_fail_idx(ffi_c), .first_fail_vld(ffv_c)
  );

  task automatic check(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int u, input logic v);
    case (u)
      0: start_a = v;
      1: start_b = v;
      default: start_c = v;
    endcase
  endtask

  function automatic logic done_of(input int u);
    case (u)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  // lat = edges from the start-sampling edge until done is seen
  task automatic run(input int u, input bit poke,
                     output int lat);
    set_start(u, 1'b1);
    tick();
    set_start(u, 1'b0);
    lat = 0;
    while (!done_of(u) && lat < 200) begin
      tick();
      lat++;
      set_start(u, poke && lat == 6);
    end
    set_start(u, 1'b0);
  endtask

  initial begin
    int  lat;
    int  n;
    bit  seen;
    n_run  = 0;
    n_fail = 0;
    pt_a[0] = PT1;  key_a[0] = '0;
    ct_a[0] = CT1;
    pt_a[1] = 128'h0123456789abcdef0123456789abcdef;
    key_a[1] = 128'h11;
    ct_a[1] = 128'hdeadbeefcafef00d1234567887654321;
    pt_a[2] = 128'h55555555aaaaaaaa55555555aaaaaaaa;
    key_a[2] = 128'h22;
    ct_a[2] = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    pt_a[3] = 128'h00000000000000000000000000000042;
    key_a[3] = 128'h33;
    ct_a[3] = 128'hfedcba9876543210fedcba9876543210;
    pt_c[0] = PT2;  key_c[0] = KEY2;  ct_c[0] = CT2;
    for (int i = 1; i < 5; i++) begin
      pt_c[i]  = {16{8'(i * 17)}};
      key_c[i] = {32{8'(i)}};
      ct_c[i]  = ~pt_c[i] ^ 128'h5a;
    end
    ctflip_a = 0;  decflip_a = 0;  fmask_c = '0;
    start_a = 0;  loop_a = 0;  abort_a = 0;
    start_b = 0;  loop_b = 0;  abort_b = 0;
    start_c = 0;  loop_c = 0;  abort_c = 0;
    reset = 1'b1;
    tick();
    tick();
    check("rst_idx", idx_a, 0);
    check("rst_pt", cpt_a, 0);
    check("rst_key", ckey_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_pass", pass_a, 0);
    check("rst_cnt", {ecnt_a, dcnt_a}, 0);
    check("rst_ff", {ffi_a, ffv_a}, 0);
    reset = 1'b0;
    tick();

    run(1, 0, lat);
    check("t1_lat", lat, 4);
    check("t1_pass", pass_b, 1);
    check("t1_cnt", {ecnt_b, dcnt_b}, 0);
    check("t1_ffv", ffv_b, 0);
    check("t1_pt", cpt_b, PT1);
    tick();
    check("t1_idle", {busy_b, done_b}, 0);

    run(2, 0, lat);
    check("t2_lat", lat, 20);
    check("t2_pass", pass_c, 1);
    check("t2_cnt", {ecnt_c, dcnt_c}, 0);
    check("t2_key", ckey_c, key_c[4]);
    tick();

    ctflip_a = 1;
    run(0, 0, lat);
    check("t3_lat", lat, 16);
    check("t3_enc", ecnt_a, 1);
    check("t3_dec", dcnt_a, 0);
    check("t3_ffi", ffi_a, 2);
    check("t3_ffv", ffv_a, 1);
    check("t3_pass", pass_a, 0);
    check("t3_busy", busy_a, 1);
    tick();
    check("t3_pulse", {busy_a, done_a}, 0);
    ctflip_a = 0;

    decflip_a = 1;
    run(0, 1, lat);
    check("t4_lat", lat, 16);
    check("t4_dec", dcnt_a, 4);
    check("t4_enc", ecnt_a, 0);
    check("t4_ffi", ffi_a, 0);
    check("t4_pass", pass_a, 0);
    tick();

    start_a = 1;
    tick();
    start_a = 0;
    for (int i = 0; i < 5; i++) tick();
    check("t5_idx", idx_a, 1);
    check("t5_pre_dec", dcnt_a, 1);
    abort_a = 1;
    tick();
    abort_a = 0;
    check("t5_busy", busy_a, 0);
    check("t5_hold", {ecnt_a, dcnt_a}, {8'd0, 8'd1});
    check("t5_ffv", ffv_a, 1);
    check("t5_pass", pass_a, 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done_a || busy_a) seen = 1;
    end
    check("t5_quiet", seen, 0);
    decflip_a = 0;
    run(0, 0, lat);
    check("t5_lat", lat, 16);
    check("t5_clr", {ecnt_a, dcnt_a}, 0);
    check("t5_ffv2", ffv_a, 0);
    check("t5_pass2", pass_a, 1);
    tick();
    start_a = 1;
    abort_a = 1;
    tick();
    start_a = 0;
    abort_a = 0;
    check("sa_busy", busy_a, 0);
    check("sa_pass", pass_a, 0);
    check("sa_idx", idx_a, 3);
    tick();
    check("sa_idle", busy_a, 0);

    fmask_c = 5'b00100;
    loop_c = 1;
    run(2, 0, lat);
    check("t6_lat", lat, 20);
    check("t6_enc0", ecnt_c, 1);
    for (int r = 1; r < 5; r++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!done_c && n < 100);
      check($sformatf("t6_per%0d", r), n, 21);
      check($sformatf("t6_enc%0d", r), ecnt_c, 1);
      check($sformatf("t6_ffi%0d", r), ffi_c, 2);
    end
    loop_c = 0;
    tick();
    check("t6_stop", {busy_c, done_c}, 0);
    check("t6_pass", pass_c, 0);

    fmask_c = 5'b11111;
    run(2, 0, lat);
    check("sat_enc", ecnt_c, 3);
    check("sat_dec", dcnt_c, 0);
    check("sat_ff", {ffi_c, ffv_c}, {3'd0, 1'b1});
    check("sat_pass", pass_c, 0);
    tick();

    start_b = 1;
    tick();
    start_b = 0;
    tick();
    tick();
    reset = 1;
    tick();
    reset = 0;
    check("mr_busy", busy_b, 0);
    check("mr_pt", cpt_b, 0);
    check("mr_pass", pass_b, 0);
    tick();
    check("mr_idle", {busy_b, done_b}, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
